load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
// - Sits between the core's memory stage and the negedge-clocked word RAM.
// - Accepts byte/half/word load and store requests and drives the RAM address, byte write mask and lane-shifted write data.
// - Aligns and sign/zero-extends read data into a single-pulse response.
// - Optionally splits word-crossing accesses into two RAM beats.
// PARAMETERS
// - RAM_WORDS  2048  words behind the RAM; a beat whose address[31:2] >= RAM_WORDS faults.
// PORTS
// - clk                 in   1   clock; RAM side samples on negedge.
// - reset_n             in   1   synchronous, active-low reset.
// - req_valid_in        in   1   request valid.
// - req_ready_out       out  1   unit can accept a request this cycle.
// - req_write_in        in   1   1 = store, 0 = load.
// - req_size_in         in   2   00 byte, 01 half, 10 word, 11 reserved (faults).
// - req_unsigned_in     in   1   load zero-extends when 1, sign-extends when 0.
// - req_address_in      in   32  byte address.
// - req_write_value_in  in   32  store data, right-justified.
// - rsp_valid_out       out  1   one-cycle completion pulse (loads and stores).
// - rsp_fault_out       out  1   qualifies rsp_valid_out; access not performed.
// - rsp_read_value_out  out  32  extended load data; 0 for stores and faults.
// - ram_address_out     out  32  RAM byte address, word-aligned, registered.
// - ram_write_mask_out  out  4   byte-lane write enables, lane k = bits [8k+7:8k].
// - ram_write_value_out out  32  lane-shifted store data.
// - ram_read_value_in   in   32  RAM read word; valid before the posedge after address drive.
// BEHAVIOUR
// - States: IDLE, BEAT0, BEAT1, RESP.
//   - req_ready_out = reset_n && (IDLE || RESP).
//   - A handshake captures all req_* fields into registers.
// - Decode at acceptance (off = addr[1:0], n = 1/2/4 bytes):
//   - Fault when size = 11, or an access beat is out of bounds.
//   - Without MISALIGNED_EN, also fault when addr % n != 0.
//   - A faulting request goes directly to RESP. It performs no RAM write and yields rsp_fault_out = 1.
// - BEAT0:
//   - ram_address_out = {addr[31:2], 2'b00}.
//   - Mask = n ones << off, truncated to 4 bits.
//   - Data = wdata << 8*off.
//   - At the posedge, load data is captured into a beat-0 register.
//   - Next state is BEAT1 if off + n > 4, else RESP.
// - BEAT1:
//   - Address = previous word + 4, mod 2^32 (0xFFFFFFFC wraps to 0).
//   - Mask = remaining low lanes.
//   - Data = wdata >> 8*(4-off).
//   - Load data is captured, then next state is RESP.
// - Load result:
//   - Combine (beat0 >> 8*off) | (beat1 << 8*(4-off)).
//   - Keep the low 8n bits, then sign- or zero-extend to 32.
// - RESP:
//   - rsp_valid_out = 1 for exactly one cycle.
//   - A new request accepted in RESP goes to BEAT0 (or RESP if it faults).
//   - Otherwise RESP goes to IDLE.
// - Latency, acceptance edge to rsp_valid_out high:
//   - aligned / in-word access: 2 cycles;
//   - split access: 3 cycles;
//   - fault: 1 cycle.
//   - Back-to-back throughput is one in-word access per 2 cycles.
// - ram_write_mask_out is nonzero only in BEAT0/BEAT1 of a store. It is forced to 0 combinationally whenever reset_n = 0.
// - Reset (including mid-access):
//   - state = IDLE; rsp_valid_out = 0, rsp_fault_out = 0.
//   - rsp_read_value_out = 0, ram_address_out = 0.
//   - ram_write_mask_out = 0, ram_write_value_out = 0.
//   - An aborted split store may have written beat 0 only.
// - No response backpressure: the consumer must take rsp_* on the pulse.
// CONFIGURATION
// - MISALIGNED_EN defined:
//   - Any offset is legal.
//   - In-word misaligned accesses take one beat; word-crossing accesses take two.
// - MISALIGNED_EN undefined:
//   - BEAT1 is never entered.
//   - Natural misalignment faults with no RAM access.
// TESTING
// - Store word 0xDEADBEEF @0x10, then load word @0x10:
//   - store beat mask = 1111;
//   - load returns 0xDEADBEEF, fault = 0, 2 cycles after acceptance.
// - Store byte 0x80 @0x13, then signed/unsigned byte load @0x13:
//   - mask = 1000, data = 0x80000000;
//   - loads return 0xFFFFFF80 / 0x00000080.
// - MISALIGNED_EN defined, word store 0x11223344 @0x1E:
//   - beat0 @0x1C mask 1100 data 0x33440000;
//   - beat1 @0x20 mask 0011 data 0x00001122;
//   - reload returns 0x11223344 after 3 cycles.
// - MISALIGNED_EN undefined, half load @0x01:
//   - rsp_fault_out = 1 next cycle;
//   - ram_write_mask_out stays 0;
//   - rsp_read_value_out = 0.
// - Word load @0x2000 (RAM_WORDS = 2048) -> fault; size = 11 -> fault.
// - Assert reset_n = 0 in BEAT0 of a store:
//   - mask is 0 that cycle;
//   - unit returns to IDLE;
//   - no rsp_valid_out;
//   - req_ready_out = 1 the cycle after reset_n rises.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit: byte/half/word load-store front end for a negedge-clocked word RAM.
// Ports:
//   clk, reset_n (synchronous, active-low)
//   req_*  : request handshake (valid/ready), store flag, size, unsigned, address, store data
//   rsp_*  : one-cycle completion pulse with fault flag and extended load data
//   ram_*  : registered word address, byte-lane write mask, lane-shifted store data, read word
// Build option: define MISALIGNED_EN to allow any offset (word-crossing accesses take two beats);
// otherwise naturally misaligned requests fault without touching the RAM.
module load_store_unit #(
  parameter int RAM_WORDS = 2048
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid_in,
  output logic        req_ready_out,
  input  logic        req_write_in,
  input  logic [1:0]  req_size_in,
  input  logic        req_unsigned_in,
  input  logic [31:0] req_address_in,
  input  logic [31:0] req_write_value_in,
  output logic        rsp_valid_out,
  output logic        rsp_fault_out,
  output logic [31:0] rsp_read_value_out,
  output logic [31:0] ram_address_out,
  output logic [3:0]  ram_write_mask_out,
  output logic [31:0] ram_write_value_out,
  input  logic [31:0] ram_read_value_in
);
  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;
  localparam logic [31:0] WORDS = RAM_WORDS;
  state_t state, nxt;
  logic write_q, uns_q, split_q;
  logic [1:0] size_q, off_q, off;
  logic [31:0] wdata_q, beat0_q, aligned, ext;
  logic [3:0] mask_q;
  logic [2:0] n;
  logic [7:0] lanes;
  logic [29:0] next_word;
  logic [5:0] hi_shift;
  logic [63:0] joined;
  logic accept, split, misaligned, oob0, oob1, fault, last_beat;
  // Byte-lane pattern of an access spread over two words: low nibble is beat 0, high nibble beat 1.
  function automatic logic [7:0] lane_span(input logic [1:0] size, input logic [1:0] o);
    return {4'b0000, size == 2'd0 ? 4'b0001 : size == 2'd1 ? 4'b0011 : 4'b1111} << o;
  endfunction
  assign off = req_address_in[1:0];
  assign n = req_size_in == 2'd0 ? 3'd1 : req_size_in == 2'd1 ? 3'd2 : 3'd4;
  assign split = {1'b0, off} + n > 3'd4;
  assign misaligned = req_size_in == 2'd1 ? off[0] : req_size_in == 2'd2 ? off != 2'd0 : 1'b0;
  assign next_word = req_address_in[31:2] + 30'd1;
  assign oob0 = {2'b00, req_address_in[31:2]} >= WORDS;
  assign oob1 = {2'b00, next_word} >= WORDS;
`ifdef MISALIGNED_EN
  assign fault = req_size_in == 2'd3 || oob0 || (split && oob1);
`else
  assign fault = req_size_in == 2'd3 || oob0 || misaligned;
`endif
  assign req_ready_out = reset_n && (state == IDLE || state == RESP);
  assign accept = req_valid_in && req_ready_out;
  // In BEAT0 the lanes describe the captured request (for the beat-1 half); otherwise the incoming one.
  assign lanes = state == BEAT0 ? lane_span(size_q, off_q) : lane_span(req_size_in, off);
  assign hi_shift = {3'd4 - {1'b0, off_q}, 3'b000};
  assign last_beat = (state == BEAT0 && !split_q) || state == BEAT1;
  // Beat 0 comes straight from the RAM on an in-word access, from the holding register after a split.
  assign joined = {ram_read_value_in, state == BEAT1 ? beat0_q : ram_read_value_in};
  assign aligned = 32'(joined >> {off_q, 3'b000});
  assign ext = size_q == 2'd0 ? {{24{~uns_q & aligned[7]}}, aligned[7:0]} :
               size_q == 2'd1 ? {{16{~uns_q & aligned[15]}}, aligned[15:0]} : aligned;
  assign ram_write_mask_out = reset_n ? mask_q : 4'b0000;
  always_comb begin
    nxt = state == BEAT0 ? (split_q ? BEAT1 : RESP) :
          state == BEAT1 ? RESP :
          accept ? (fault ? RESP : BEAT0) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      write_q <= 1'b0;
      uns_q <= 1'b0;
      split_q <= 1'b0;
      size_q <= 2'd0;
      off_q <= 2'd0;
      wdata_q <= 32'd0;
      beat0_q <= 32'd0;
      mask_q <= 4'b0000;
      ram_address_out <= 32'd0;
      ram_write_value_out <= 32'd0;
      rsp_valid_out <= 1'b0;
      rsp_fault_out <= 1'b0;
      rsp_read_value_out <= 32'd0;
    end else begin
      state <= nxt;
      mask_q <= 4'b0000;
      if (accept) begin
        write_q <= req_write_in;
        uns_q <= req_unsigned_in;
        split_q <= split;
        size_q <= req_size_in;
        off_q <= off;
        wdata_q <= req_write_value_in;
      end
      if (state == BEAT0)
        beat0_q <= ram_read_value_in;
      if (accept && !fault) begin
        ram_address_out <= {req_address_in[31:2], 2'b00};
        mask_q <= req_write_in ? lanes[3:0] : 4'b0000;
        ram_write_value_out <= req_write_value_in << {off, 3'b000};
      end else if (state == BEAT0 && split_q) begin
        ram_address_out <= ram_address_out + 32'd4;
        mask_q <= write_q ? lanes[7:4] : 4'b0000;
        ram_write_value_out <= wdata_q >> hi_shift;
      end
      rsp_valid_out <= nxt == RESP;
      rsp_fault_out <= accept && fault;
      rsp_read_value_out <= last_beat && !write_q ? ext : 32'd0;
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: randomized check of load_store_unit against a byte-addressed memory model.
module tb_load_store_unit;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic req_valid = 1'b0, req_ready, req_write = 1'b0, req_unsigned = 1'b0;
  logic [1:0] req_size = 2'd0;
  logic [31:0] req_address = 32'd0, req_write_value = 32'd0;
  logic rsp_valid, rsp_fault;
  logic [31:0] rsp_read_value, ram_address, ram_write_value;
  logic [31:0] ram_read_value = 32'd0;
  logic [3:0] ram_write_mask;
  logic [31:0] ram [0:2047];
  logic [7:0] ref_mem [0:8191];
  int n_chk = 0, n_fail = 0;

  load_store_unit #(.RAM_WORDS(2048)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid_in(req_valid), .req_ready_out(req_ready), .req_write_in(req_write),
    .req_size_in(req_size), .req_unsigned_in(req_unsigned), .req_address_in(req_address),
    .req_write_value_in(req_write_value),
    .rsp_valid_out(rsp_valid), .rsp_fault_out(rsp_fault), .rsp_read_value_out(rsp_read_value),
    .ram_address_out(ram_address), .ram_write_mask_out(ram_write_mask),
    .ram_write_value_out(ram_write_value), .ram_read_value_in(ram_read_value)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    logic [31:0] w;
    if (ram_address[31:13] == 19'd0) begin
      w = ram[ram_address[12:2]];
      for (int k = 0; k < 4; k++)
        if (ram_write_mask[k]) w[8*k +: 8] = ram_write_value[8*k +: 8];
      ram[ram_address[12:2]] <= w;
      ram_read_value <= ram[ram_address[12:2]];
    end else begin
      ram_read_value <= 32'd0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issues one request at the current cycle (called #1 after a posedge, unit ready) and follows it
  // to its response, checking every beat against expectations derived byte by byte.
  task automatic do_req(input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd);
    int n, lat;
    logic flt, spl;
    logic [31:0] b, lm, exp_rd;
    logic [3:0] emask [2];
    logic [31:0] edata [2];
    logic [63:0] v;
    n = sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : sz == 2'd2 ? 4 : 0;
    flt = sz == 2'd3;
    for (int i = 0; i < n; i++) begin
      b = a + i;
      if (b[31:2] >= 30'd2048) flt = 1'b1;
    end
`ifndef MISALIGNED_EN
    if (n != 0 && a % n != 0) flt = 1'b1;
`endif
    spl = !flt && (a % 4 + n > 4);
    lat = flt ? 1 : spl ? 3 : 2;
    for (int k = 0; k < 2; k++) begin
      emask[k] = 4'b0000;
      edata[k] = 32'd0;
    end
    v = 64'd0;
    for (int i = 0; i < n; i++) begin
      int k, lane;
      b = a + i;
      k = b[31:2] != a[31:2] ? 1 : 0;
      lane = int'(b[1:0]);
      if (wr) begin
        emask[k][lane] = 1'b1;
        edata[k][8*lane +: 8] = wd[8*i +: 8];
      end
      v |= 64'(ref_mem[b % 8192]) << (8 * i);
    end
    if (!uns && n > 0 && v[8*n-1]) v |= ~((64'd1 << (8 * n)) - 64'd1);
    exp_rd = (wr || flt) ? 32'd0 : v[31:0];
    chk("req_ready", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_write = wr;
    req_size = sz;
    req_unsigned = uns;
    req_address = a;
    req_write_value = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    for (int k = 1; k <= lat; k++) begin
      if (k < lat) begin
        lm = {{8{ram_write_mask[3]}}, {8{ram_write_mask[2]}}, {8{ram_write_mask[1]}}, {8{ram_write_mask[0]}}};
        chk("busy_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("busy_ready", {31'd0, req_ready}, 32'd0);
        chk("beat_address", ram_address, {a[31:2], 2'b00} + 32'(4 * (k - 1)));
        chk("beat_mask", {28'd0, ram_write_mask}, {28'd0, emask[k-1]});
        chk("beat_data", ram_write_value & lm, edata[k-1]);
        @(posedge clk);
        #1;
      end else begin
        chk("rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("rsp_fault", {31'd0, rsp_fault}, {31'd0, flt});
        chk("rsp_read_value", rsp_read_value, exp_rd);
        chk("rsp_mask", {28'd0, ram_write_mask}, 32'd0);
      end
    end
    if (wr && !flt)
      for (int i = 0; i < n; i++) begin
        b = a + i;
        ref_mem[b % 8192] = wd[8*i +: 8];
      end
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      chk("idle_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("idle_ready", {31'd0, req_ready}, 32'd1);
    end
  endtask

  initial begin
    logic [1:0] sz;
    logic [31:0] a;
    int r;
    for (int i = 0; i < 2048; i++) ram[i] = 32'd0;
    for (int i = 0; i < 8192; i++) ref_mem[i] = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_fault", {31'd0, rsp_fault}, 32'd0);
    chk("rst_rsp_read_value", rsp_read_value, 32'd0);
    chk("rst_ram_address", ram_address, 32'd0);
    chk("rst_ram_mask", {28'd0, ram_write_mask}, 32'd0);
    chk("rst_ram_value", ram_write_value, 32'd0);
    chk("rst_ready", {31'd0, req_ready}, 32'd0);
    reset_n = 1'b1;
    idle(1);
    do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF);
    idle(1);
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    chk("word_reload", rsp_read_value, 32'hDEADBEEF);
    do_req(1'b1, 2'd0, 1'b0, 32'h13, 32'h80);
    do_req(1'b0, 2'd0, 1'b0, 32'h13, 32'h0);
    chk("byte_signed", rsp_read_value, 32'hFFFFFF80);
    do_req(1'b0, 2'd0, 1'b1, 32'h13, 32'h0);
    chk("byte_unsigned", rsp_read_value, 32'h00000080);
`ifdef MISALIGNED_EN
    do_req(1'b1, 2'd2, 1'b0, 32'h1E, 32'h11223344);
    do_req(1'b0, 2'd2, 1'b0, 32'h1E, 32'h0);
    chk("split_reload", rsp_read_value, 32'h11223344);
`else
    do_req(1'b0, 2'd1, 1'b0, 32'h01, 32'h0);
    chk("misaligned_fault", {31'd0, rsp_fault}, 32'd1);
`endif
    do_req(1'b0, 2'd2, 1'b0, 32'h2000, 32'h0);
    chk("oob_fault", {31'd0, rsp_fault}, 32'd1);
    do_req(1'b0, 2'd3, 1'b0, 32'h20, 32'h0);
    chk("size3_fault", {31'd0, rsp_fault}, 32'd1);
    idle(1);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_size = 2'd2;
    req_address = 32'h40;
    req_write_value = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("abort_mask", {28'd0, ram_write_mask}, 32'd0);
    chk("abort_ready", {31'd0, req_ready}, 32'd0);
    @(posedge clk);
    #1;
    chk("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("abort_address", ram_address, 32'd0);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_ready_after", {31'd0, req_ready}, 32'd1);
    chk("abort_no_rsp", {31'd0, rsp_valid}, 32'd0);
    do_req(1'b0, 2'd2, 1'b0, 32'h40, 32'h0);
    for (int it = 0; it < 300; it++) begin
      sz = $urandom_range(0, 15) == 0 ? 2'd3 : 2'($urandom_range(0, 2));
      r = $urandom_range(0, 9);
      a = r < 7 ? 32'($urandom_range(0, 63)) :
          r < 9 ? 32'h1FF8 + 32'($urandom_range(0, 15)) : 32'hFFFFFFF8 + 32'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1 && sz != 2'd3)
        a = a & ~((32'd1 << sz) - 32'd1);
      do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
      idle($urandom_range(0, 2));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
